// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the serial receive sequencer.
// Optional even-parity support is selected with UART_RX_PARITY_EN.
package uart_rx_pkg;

  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_CLKS_PER_BIT = 10;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY_CHK,
`endif
    STOP,
    LOAD,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/rx_timer.sv
// Wrapping counter: counts 1..rollover_val, then wraps back to 1.
// Reset and clear both force the count to 0.
module rx_timer #(
  parameter int CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                count_enable,
  input  logic [CNT_BITS-1:0] rollover_val,
  output logic [CNT_BITS-1:0] count_out,
  output logic                rollover_flag
);

  logic [CNT_BITS-1:0] count_q;
  logic [CNT_BITS-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = (count_q == rollover_val) ? CNT_BITS'(1) : count_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/uart_rx_sequencer.sv
// Serial receive sequencer: start detect, mid-bit sampling, framing and overrun reporting.
// Define UART_RX_PARITY_EN to expect an even-parity bit and expose parity_error.
module uart_rx_sequencer
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_BITS     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_error
`endif
);

  localparam int HALF     = CLKS_PER_BIT / 2;
  localparam int IDX_BITS = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  rx_state_t state_q, state_d;
  logic                 serial_prev_q;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 data_ready_q, data_ready_d;
  logic                 overrun_q, overrun_d;
  logic                 framing_q, framing_d;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit_q, parity_bit_d;
  logic                 parity_err_q, parity_err_d;
`endif

  logic                 in_bit_timing;
  logic [CNT_BITS-1:0]  bit_roll, bit_cnt;
  logic                 bit_tick;
  logic [IDX_BITS-1:0]  idx_cnt;
  logic                 idx_last;
  logic                 start_detect;
  logic                 cnt_unused;

  assign start_detect = serial_prev_q & ~serial_in;
  // Start check lands one period early so its wrap to 1 phases the data samples to bit centres.
  assign bit_roll     = (state_q == START_CHK) ? CNT_BITS'(HALF - 1) : CNT_BITS'(CLKS_PER_BIT);
  assign cnt_unused   = ^{bit_cnt, idx_cnt};

  always_comb begin
    in_bit_timing = 1'b0;
    case (state_q)
      START_CHK, DATA, STOP: in_bit_timing = 1'b1;
`ifdef UART_RX_PARITY_EN
      PARITY_CHK:            in_bit_timing = 1'b1;
`endif
      default:               in_bit_timing = 1'b0;
    endcase
  end

  rx_timer #(.CNT_BITS(CNT_BITS)) u_bit_timer (
    .clk           (clk),
    .rst           (rst),
    .clear         (~in_bit_timing),
    .count_enable  (in_bit_timing),
    .rollover_val  (bit_roll),
    .count_out     (bit_cnt),
    .rollover_flag (bit_tick)
  );

  rx_timer #(.CNT_BITS(IDX_BITS)) u_idx_timer (
    .clk           (clk),
    .rst           (rst),
    .clear         (state_q == START_CHK),
    .count_enable  ((state_q == DATA) && bit_tick),
    .rollover_val  (IDX_BITS'(DATA_BITS - 1)),
    .count_out     (idx_cnt),
    .rollover_flag (idx_last)
  );

  // Consumer handshake: data_ready stays high until a cycle with data_read; a load
  // in the same cycle as data_read wins, keeping data_ready and clearing overrun.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;
    framing_d    = framing_q;
`ifdef UART_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
    parity_err_d = parity_err_q;
`endif
    if (data_read) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (start_detect) begin
          state_d   = START_CHK;
          framing_d = 1'b0;
        end
      end
      START_CHK: begin
        if (bit_tick) state_d = serial_in ? IDLE : DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = {serial_in, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
          if (idx_last) state_d = PARITY_CHK;
`else
          if (idx_last) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY_CHK: begin
        if (bit_tick) begin
          parity_bit_d = serial_in;
          state_d      = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (serial_in) begin
            state_d = LOAD;
          end else begin
            framing_d = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end
      end
      LOAD: begin
        rx_data_d    = shift_q;
        data_ready_d = 1'b1;
        overrun_d    = data_ready_q & ~data_read;
`ifdef UART_RX_PARITY_EN
        parity_err_d = (^shift_q) ^ parity_bit_q;
`endif
        state_d      = IDLE;
      end
      WAIT_IDLE: begin
        if (serial_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      serial_prev_q <= 1'b0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      data_ready_q  <= 1'b0;
      overrun_q     <= 1'b0;
      framing_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q  <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      serial_prev_q <= serial_in;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      data_ready_q  <= data_ready_d;
      overrun_q     <= overrun_d;
      framing_q     <= framing_d;
`ifdef UART_RX_PARITY_EN
      parity_bit_q  <= parity_bit_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign rx_data       = rx_data_q;
  assign data_ready    = data_ready_q;
  assign overrun_error = overrun_q;
  assign framing_error = framing_q;
  assign busy          = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_error  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer with default parameters (8 data bits, 10 clocks per bit).
module tb_uart_rx_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic       data_read;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       overrun_error;
  logic       framing_error;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .data_read     (data_read),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error),
`ifdef UART_RX_PARITY_EN
    .parity_error  (parity_error),
`endif
    .busy          (busy)
  );

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drops the line; returns just after edge T0 (start detect).
  task automatic begin_frame();
    serial_in = 1'b0;
    tick(1);
  endtask

  // Completes the start bit and drives the data bits LSB first; returns after edge T0+89.
  task automatic send_data(input logic [7:0] d);
    tick(9);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      tick(10);
    end
  endtask

  // Whole frame with a good stop bit; returns after edge T0+99.
  task automatic frame(input logic [7:0] d);
    begin_frame();
    send_data(d);
    serial_in = 1'b1;
    tick(10);
    exp_q.push_back(d);
  endtask

  // The newest queued character is what rx_data must show.
  task automatic check_rx(input string tag);
    logic [7:0] e;
    e = exp_q[$];
    exp_q.delete();
    check(tag, int'(rx_data), int'(e));
  endtask

  task automatic pulse_read();
    data_read = 1'b1;
    tick(1);
    data_read = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    serial_in = 1'b0;
    data_read = 1'b0;
    tick(3);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_data_ready", int'(data_ready), 0);
    check("rst_overrun", int'(overrun_error), 0);
    check("rst_framing", int'(framing_error), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick(3);
    check("low_across_rst_no_start", int'(busy), 0);
    serial_in = 1'b1;
    tick(12);

    // Clean frame 0xA5
    begin_frame();
    check("a5_busy_t0", int'(busy), 1);
    send_data(8'hA5);
    serial_in = 1'b1;
    tick(6);
    check("a5_fe_ts", int'(framing_error), 0);
    check("a5_dr_before_load", int'(data_ready), 0);
    check("a5_busy_ts", int'(busy), 1);
    tick(1);
    exp_q.push_back(8'hA5);
    check_rx("a5_rx_data");
    check("a5_dr", int'(data_ready), 1);
    tick(1);
    check("a5_busy_done", int'(busy), 0);
    check("a5_fe", int'(framing_error), 0);
    check("a5_overrun", int'(overrun_error), 0);
    tick(2);
    pulse_read();
    check("a5_read_clears_dr", int'(data_ready), 0);
    tick(3);

    // False start: line low for 3 cycles
    begin_frame();
    tick(2);
    serial_in = 1'b1;
    tick(2);
    check("false_busy_t4", int'(busy), 1);
    tick(1);
    check("false_busy_t5", int'(busy), 0);
    tick(1);
    check("false_busy_t6", int'(busy), 0);
    check("false_dr", int'(data_ready), 0);
    tick(10);

    // Frame 0x5A with a zero stop bit
    begin_frame();
    send_data(8'h5A);
    serial_in = 1'b0;
    tick(6);
    check("fe_set_ts", int'(framing_error), 1);
    check("fe_no_load", int'(data_ready), 0);
    tick(10);
    check("fe_busy_line_low", int'(busy), 1);
    serial_in = 1'b1;
    tick(1);
    check("fe_idle_line_high", int'(busy), 0);
    tick(2);
    check("fe_persists", int'(framing_error), 1);
    begin_frame();
    check("fe_clear_t0", int'(framing_error), 0);
    send_data(8'h3C);
    serial_in = 1'b1;
    tick(10);
    exp_q.push_back(8'h3C);
    check_rx("3c_rx_data");
    check("3c_dr", int'(data_ready), 1);
    pulse_read();
    tick(2);

    // Two unread frames back to back
    frame(8'h11);
    frame(8'h22);
    check_rx("ovr_rx_data");
    check("ovr_dr", int'(data_ready), 1);
    check("ovr_set", int'(overrun_error), 1);
    pulse_read();
    check("ovr_read_dr", int'(data_ready), 0);
    check("ovr_read_clear", int'(overrun_error), 0);
    check("ovr_rx_kept", int'(rx_data), 'h22);
    tick(3);

    // Reset in the middle of data bit 3
    frame(8'h44);
    exp_q.delete();
    begin_frame();
    tick(9);
    for (int i = 0; i < 3; i++) begin
      serial_in = 1'b1;
      tick(10);
    end
    serial_in = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    check("midrst_rx_data", int'(rx_data), 0);
    check("midrst_dr", int'(data_ready), 0);
    check("midrst_overrun", int'(overrun_error), 0);
    check("midrst_fe", int'(framing_error), 0);
    check("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    tick(12);
    frame(8'h7E);
    check_rx("7e_rx_data");
    check("7e_dr", int'(data_ready), 1);
    check("7e_overrun", int'(overrun_error), 0);

    // data_read in the LOAD cycle of a second unread frame
    begin_frame();
    send_data(8'h96);
    serial_in = 1'b1;
    tick(6);
    data_read = 1'b1;
    tick(1);
    data_read = 1'b0;
    exp_q.push_back(8'h96);
    check_rx("loadwin_rx_data");
    check("loadwin_dr", int'(data_ready), 1);
    check("loadwin_overrun", int'(overrun_error), 0);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_sequencer.md
# uart_rx_sequencer

Serial-receive controller that sequences a bit-period timer and a bit-index count to frame, sample and deliver asynchronous serial characters. It sits between the synchronized serial input and the consumer-side data register, and owns all bit timing and framing decisions. It detects the start edge, validates the start bit at mid-bit, samples data and stop bits at bit centres, and reports framing and overrun errors.

## Interface
- DATA_BITS, 8, data bits per frame; LSB received first.
- CLKS_PER_BIT, 10, clock cycles per serial bit; must be at least 4.
- CNT_BITS, 4, timer width; must hold CLKS_PER_BIT.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- serial_in  in  1  serial line, already synchronized to clk; idles high.
- data_read  in  1  consumer acknowledge; clears data_ready and overrun_error.
- rx_data  out  DATA_BITS  last received character.
- data_ready  out  1  rx_data holds an unread character.
- overrun_error  out  1  a character was loaded while the previous one was unread.
- framing_error  out  1  the last frame had a stop bit of 0.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Let HALF = CLKS_PER_BIT/2 (floor).
- State register serial_prev holds the previous serial_in.
- Start detect: serial_prev==1 and serial_in==0.
- FSM states: IDLE, START_CHK, DATA, STOP, LOAD, WAIT_IDLE.
- IDLE → START_CHK on start detect. The timer is cleared and framing_error is cleared on this edge.
- START_CHK: wait HALF cycles, then sample serial_in.
  - 0 → DATA, with the bit index set to 0.
  - 1 → IDLE (false start). No output changes.
- DATA: sample once per CLKS_PER_BIT.
  - Each sample shifts right into the shift register, with the new bit at the MSB.
  - After DATA_BITS samples → STOP.
- STOP: sample after one more CLKS_PER_BIT.
  - 1 → LOAD.
  - 0 → framing_error<=1, then WAIT_IDLE. Data is not loaded.
- LOAD (one cycle):
  - rx_data<=shift register; data_ready<=1.
  - overrun_error<=data_ready & ~data_read.
  - Then → IDLE.
- WAIT_IDLE → IDLE once serial_in==1.
- data_read outside LOAD: data_ready<=0 and overrun_error<=0 on that edge.
- data_read coinciding with LOAD: the load wins. data_ready stays 1 and overrun_error<=0.
- framing_error persists until the next start detect or rst.
- Reset values:
  - Outputs: rx_data=0, data_ready=0, overrun_error=0, framing_error=0, busy=0.
  - Internal: shift register 0, timer 0, state IDLE.
  - serial_prev=0, so a line held low across reset is not a start.
- rst asserted mid-frame aborts the frame immediately and discards partial data.

## Timing
- T0 is the edge at which start detect is true.
- Start bit sampled at edge T0+HALF.
- Data bit i (0-based) sampled at edge T0+HALF+(i+1)·CLKS_PER_BIT.
- Stop bit sampled at edge Ts = T0+HALF+(DATA_BITS+1)·CLKS_PER_BIT.
- rx_data and data_ready are valid after edge Ts+1.
- The FSM is in IDLE after edge Ts+2, so back-to-back frames are accepted.
- framing_error is set at edge Ts.
- Timer arithmetic: unsigned CNT_BITS. The timer wraps to 1 after reaching its rollover value and never overflows.

## Configuration
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An even-parity bit is expected after the data bits, sampled at T0+HALF+(DATA_BITS+1)·CLKS_PER_BIT.
  - The stop bit moves one CLKS_PER_BIT later, and all later timing shifts by one bit.
  - Adds output parity_error (1 bit), written at every LOAD (1 on mismatch) and reset to 0.
  - Data is loaded regardless of parity.
- Undefined: no parity bit and no parity_error port.

## Structure
- Package uart_rx_pkg:
  - enum typedef rx_state_t.
  - Localparams for default DATA_BITS and CLKS_PER_BIT.
- Sub-module rx_timer:
  - Parameterized CNT_BITS.
  - Inputs: clear, count_enable, rollover_val.
  - Outputs: count_out and rollover_flag (high while count_out==rollover_val).
  - Counts 1..rollover_val.
- Two rx_timer instances: bit period, and bit index.

## Test plan
- Clean frame 0xA5 with defaults → rx_data=0xA5 and data_ready=1 after edge T0+96; framing_error=0, overrun_error=0, busy low after edge T0+97.
- False start: serial_in low for 3 cycles → state IDLE at T0+5, busy=0 after T0+6, data_ready stays 0.
- Frame 0x5A with stop bit 0 → framing_error=1 at T0+95, data_ready=0, busy held while line low. Then frame 0x3C → framing_error=0 at its T0 and rx_data=0x3C.
- Frames 0x11 then 0x22 with no data_read → rx_data=0x22, data_ready=1, overrun_error=1. A single-cycle data_read then clears both.
- rst during data bit 3 → all outputs 0 and busy=0 on the next edge. Next frame 0x7E is received correctly.
- data_read asserted in the LOAD cycle of the second of two unread frames → data_ready=1, overrun_error=0.
